// File: rtl/blackbox_sweeper.sv
// Drives the eight {f,x,e} combinations into a combinational blackbox, holds each
// for HOLD_CYCLES cycles, captures n into a truth table and compares it to a reference.
module blackbox_sweeper #(
    parameter int HOLD_CYCLES = 2,
    parameter int ORDER       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       n,
    output logic       f,
    output logic       x,
    output logic       e,
    input  logic [7:0] expected,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] fxe_q, fxe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] tt_q, tt_d;
    logic       match_q, match_d;
    logic [7:0] exp_q, exp_d;

    // Sweep index to combination code: plain binary or reflected Gray.
    function automatic logic [2:0] code(input logic [2:0] i);
        return (ORDER == 0) ? i : (i ^ {1'b0, i[2:1]});
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fxe_d   = fxe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        match_d = match_q;
        exp_d   = exp_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    fxe_d   = code(3'd0);
                    busy_d  = 1'b1;
                    tt_d    = 8'h00;
                    match_d = 1'b0;
                    exp_d   = expected;
                end
            end
            DRIVE: begin
                if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    tt_d[code(idx_q)] = n;
                    cnt_d = 8'd0;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                        fxe_d   = 3'b000;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // Compare against the table including the sample taken this edge.
                        match_d = (tt_d == exp_q);
                    end else begin
                        idx_d = idx_q + 3'd1;
                        fxe_d = code(idx_q + 3'd1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            fxe_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= 8'h00;
            match_q <= 1'b0;
            exp_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fxe_q   <= fxe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            match_q <= match_d;
            exp_q   <= exp_d;
        end
    end

    assign f           = fxe_q[2];
    assign x           = fxe_q[1];
    assign e           = fxe_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Directed bench for blackbox_sweeper: three instances (Gray H=2, binary H=1, Gray H=3)
// share clock and reset; each is fed by a selectable blackbox stub.
module tb_blackbox_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] nmode = 2'd3;   // 0: n=f, 1: n=f^x^e, 2: n=0, 3: n=1
    int tests = 0;
    int fails = 0;

    logic       start_g2 = 1'b0, start_b1 = 1'b0, start_g3 = 1'b0;
    logic [7:0] exp_g2 = 8'h00, exp_b1 = 8'h00, exp_g3 = 8'h00;
    logic       n_g2, n_b1, n_g3;
    logic       f_g2, x_g2, e_g2, busy_g2, done_g2, match_g2;
    logic       f_b1, x_b1, e_b1, busy_b1, done_b1, match_b1;
    logic       f_g3, x_g3, e_g3, busy_g3, done_g3, match_g3;
    logic [7:0] tt_g2, tt_b1, tt_g3;

    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    always #5 clk = ~clk;

    function automatic logic nfun(input logic [1:0] m, input logic a, input logic b, input logic c);
        case (m)
            2'd0:    return a;
            2'd1:    return a ^ b ^ c;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign n_g2 = nfun(nmode, f_g2, x_g2, e_g2);
    assign n_b1 = nfun(nmode, f_b1, x_b1, e_b1);
    assign n_g3 = nfun(nmode, f_g3, x_g3, e_g3);

    blackbox_sweeper #(.HOLD_CYCLES(2), .ORDER(1)) u_g2 (
        .clk(clk), .reset(reset), .start(start_g2), .n(n_g2), .f(f_g2), .x(x_g2), .e(e_g2),
        .expected(exp_g2), .busy(busy_g2), .done(done_g2), .truth_table(tt_g2), .match(match_g2));
    blackbox_sweeper #(.HOLD_CYCLES(1), .ORDER(0)) u_b1 (
        .clk(clk), .reset(reset), .start(start_b1), .n(n_b1), .f(f_b1), .x(x_b1), .e(e_b1),
        .expected(exp_b1), .busy(busy_b1), .done(done_b1), .truth_table(tt_b1), .match(match_b1));
    blackbox_sweeper #(.HOLD_CYCLES(3), .ORDER(1)) u_g3 (
        .clk(clk), .reset(reset), .start(start_g3), .n(n_g3), .f(f_g3), .x(x_g3), .e(e_g3),
        .expected(exp_g3), .busy(busy_g3), .done(done_g3), .truth_table(tt_g3), .match(match_g3));

    // Advance k rising edges and settle just after the last one.
    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nmode = 2'd3;
        start_g2 = 1'b1; start_b1 = 1'b1; start_g3 = 1'b1;
        edges(2);
        tests++; if ({f_g2, x_g2, e_g2, busy_g2, done_g2, match_g2} !== 6'b0) begin fails++; $display("FAIL reset_ctl_g2: got %b expected 000000", {f_g2, x_g2, e_g2, busy_g2, done_g2, match_g2}); end
        tests++; if ({f_b1, x_b1, e_b1, busy_b1, done_b1, match_b1} !== 6'b0) begin fails++; $display("FAIL reset_ctl_b1: got %b expected 000000", {f_b1, x_b1, e_b1, busy_b1, done_b1, match_b1}); end
        tests++; if ({f_g3, x_g3, e_g3, busy_g3, done_g3, match_g3} !== 6'b0) begin fails++; $display("FAIL reset_ctl_g3: got %b expected 000000", {f_g3, x_g3, e_g3, busy_g3, done_g3, match_g3}); end
        tests++; if ({tt_g2, tt_b1, tt_g3} !== 24'h0) begin fails++; $display("FAIL reset_tt: got %h expected 000000", {tt_g2, tt_b1, tt_g3}); end
        start_g2 = 1'b0; start_b1 = 1'b0; start_g3 = 1'b0;
        reset = 1'b1;
        edges(3);
        tests++; if ({busy_g2, busy_b1, busy_g3, f_g2, x_g2, e_g2} !== 6'b0) begin fails++; $display("FAIL reset_idle: got %b expected 000000", {busy_g2, busy_b1, busy_g3, f_g2, x_g2, e_g2}); end
    endtask

    task automatic test_gray_h2;
        nmode = 2'd0;
        exp_g2 = 8'hF0; start_g2 = 1'b1;
        edges(1);
        start_g2 = 1'b0;
        tests++; if ({f_g2, x_g2, e_g2, busy_g2} !== 4'b0001) begin fails++; $display("FAIL g2_edge0: got %b expected 0001", {f_g2, x_g2, e_g2, busy_g2}); end
        for (int k = 1; k < 16; k++) begin
            edges(1);
            tests++; if ({f_g2, x_g2, e_g2, busy_g2, done_g2} !== {gseq[k / 2], 2'b10}) begin fails++; $display("FAIL g2_seq[%0d]: got %b expected %b", k, {f_g2, x_g2, e_g2, busy_g2, done_g2}, {gseq[k / 2], 2'b10}); end
            if (k == 10) begin
                tests++; if (tt_g2 !== 8'h40) begin fails++; $display("FAIL g2_partial_tt: got %h expected 40", tt_g2); end
            end
        end
        edges(1);
        tests++; if ({done_g2, busy_g2, match_g2, f_g2, x_g2, e_g2} !== 6'b101000) begin fails++; $display("FAIL g2_done: got %b expected 101000", {done_g2, busy_g2, match_g2, f_g2, x_g2, e_g2}); end
        tests++; if (tt_g2 !== 8'hF0) begin fails++; $display("FAIL g2_tt: got %h expected f0", tt_g2); end
        edges(1);
        tests++; if ({done_g2, busy_g2, match_g2} !== 3'b001) begin fails++; $display("FAIL g2_after: got %b expected 001", {done_g2, busy_g2, match_g2}); end
    endtask

    task automatic test_binary_h1;
        nmode = 2'd1;
        exp_b1 = 8'h96; start_b1 = 1'b1;
        edges(1);
        start_b1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) edges(1);
            tests++; if ({f_b1, x_b1, e_b1} !== 3'(k)) begin fails++; $display("FAIL b1_seq[%0d]: got %b expected %b", k, {f_b1, x_b1, e_b1}, 3'(k)); end
        end
        edges(1);
        tests++; if ({done_b1, busy_b1, match_b1, tt_b1} !== {3'b101, 8'h96}) begin fails++; $display("FAIL b1_done96: got %b/%h expected 101/96", {done_b1, busy_b1, match_b1}, tt_b1); end
        edges(1);
        tests++; if (done_b1 !== 1'b0) begin fails++; $display("FAIL b1_done_pulse: got %b expected 0", done_b1); end
        exp_b1 = 8'h69; start_b1 = 1'b1;
        edges(1);
        start_b1 = 1'b0;
        tests++; if ({busy_b1, match_b1, tt_b1} !== {2'b10, 8'h00}) begin fails++; $display("FAIL b1_restart_clear: got %b/%h expected 10/00", {busy_b1, match_b1}, tt_b1); end
        edges(8);
        tests++; if ({done_b1, match_b1, tt_b1} !== {2'b10, 8'h96}) begin fails++; $display("FAIL b1_done69: got %b/%h expected 10/96", {done_b1, match_b1}, tt_b1); end
    endtask

    task automatic test_reset_mid_sweep;
        nmode = 2'd0;
        exp_g3 = 8'hF0; start_g3 = 1'b1;
        edges(1);
        start_g3 = 1'b0;
        edges(7);
        tests++; if ({f_g3, x_g3, e_g3, busy_g3} !== 4'b0111) begin fails++; $display("FAIL g3_mid: got %b expected 0111", {f_g3, x_g3, e_g3, busy_g3}); end
        #2 reset = 1'b0;
        #1;
        tests++; if ({f_g3, x_g3, e_g3, busy_g3, done_g3, match_g3, tt_g3} !== 14'b0) begin fails++; $display("FAIL g3_async_reset: got %b expected 0", {f_g3, x_g3, e_g3, busy_g3, done_g3, match_g3, tt_g3}); end
        edges(1);
        reset = 1'b1;
        start_g3 = 1'b1;
        edges(1);
        start_g3 = 1'b0;
        edges(23);
        tests++; if ({done_g3, busy_g3} !== 2'b01) begin fails++; $display("FAIL g3_edge23: got %b expected 01", {done_g3, busy_g3}); end
        edges(1);
        tests++; if ({done_g3, busy_g3, match_g3, tt_g3} !== {3'b101, 8'hF0}) begin fails++; $display("FAIL g3_done: got %b/%h expected 101/f0", {done_g3, busy_g3, match_g3}, tt_g3); end
    endtask

    task automatic test_back_to_back;
        nmode = 2'd0;
        exp_g2 = 8'hF0; start_g2 = 1'b1;
        edges(1);
        tests++; if (busy_g2 !== 1'b1) begin fails++; $display("FAIL b2b_start: got %b expected 1", busy_g2); end
        edges(15);
        tests++; if ({busy_g2, done_g2} !== 2'b10) begin fails++; $display("FAIL b2b_edge15: got %b expected 10", {busy_g2, done_g2}); end
        edges(1);
        tests++; if ({done_g2, busy_g2, match_g2, tt_g2} !== {3'b101, 8'hF0}) begin fails++; $display("FAIL b2b_done1: got %b/%h expected 101/f0", {done_g2, busy_g2, match_g2}, tt_g2); end
        edges(1);
        tests++; if ({done_g2, busy_g2, match_g2} !== 3'b001) begin fails++; $display("FAIL b2b_idle: got %b expected 001", {done_g2, busy_g2, match_g2}); end
        edges(1);
        tests++; if ({busy_g2, match_g2, tt_g2, f_g2, x_g2, e_g2} !== {2'b10, 8'h00, 3'b000}) begin fails++; $display("FAIL b2b_restart: got %b/%h expected 10/00", {busy_g2, match_g2}, tt_g2); end
        edges(16);
        tests++; if ({done_g2, match_g2} !== 2'b11) begin fails++; $display("FAIL b2b_done2: got %b expected 11", {done_g2, match_g2}); end
        edges(2);
        tests++; if ({busy_g2, match_g2} !== 2'b10) begin fails++; $display("FAIL b2b_third: got %b expected 10", {busy_g2, match_g2}); end
        edges(3);
        start_g2 = 1'b0;
        edges(13);
        tests++; if ({done_g2, match_g2} !== 2'b11) begin fails++; $display("FAIL b2b_done3: got %b expected 11", {done_g2, match_g2}); end
        edges(1);
    endtask

    task automatic test_constant_stubs;
        nmode = 2'd2; exp_b1 = 8'h00; start_b1 = 1'b1;
        edges(1);
        start_b1 = 1'b0;
        edges(8);
        tests++; if ({done_b1, match_b1, tt_b1} !== {2'b11, 8'h00}) begin fails++; $display("FAIL const0: got %b/%h expected 11/00", {done_b1, match_b1}, tt_b1); end
        edges(1);
        nmode = 2'd3; exp_b1 = 8'hFF; start_b1 = 1'b1;
        edges(1);
        start_b1 = 1'b0;
        edges(8);
        tests++; if ({done_b1, match_b1, tt_b1} !== {2'b11, 8'hFF}) begin fails++; $display("FAIL const1_ff: got %b/%h expected 11/ff", {done_b1, match_b1}, tt_b1); end
        edges(1);
        reset = 1'b0;
        #1;
        tests++; if ({match_b1, tt_b1} !== 9'b0) begin fails++; $display("FAIL held_result_reset: got %b/%h expected 0/00", match_b1, tt_b1); end
        edges(1);
        reset = 1'b1;
        exp_b1 = 8'hFE; start_b1 = 1'b1;
        edges(1);
        start_b1 = 1'b0;
        edges(8);
        tests++; if ({done_b1, match_b1, tt_b1} !== {2'b10, 8'hFF}) begin fails++; $display("FAIL const1_fe: got %b/%h expected 10/ff", {done_b1, match_b1}, tt_b1); end
    endtask

    initial begin
        test_reset();
        test_gray_h2();
        test_binary_h1();
        test_reset_mid_sweep();
        test_back_to_back();
        test_constant_stubs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
